fetch_pipe: RTL and testbench

Parametrised instruction-fetch stage for the pipelined adder datapath. It replaces the fixed 10-entry, free-running fetch with the following:
- a loadable instruction memory of configurable width and depth;
- a runtime wrap limit;
- a branch/redirect input;
- a valid/ready handshake toward decode, so a stalled decoder holds the fetched instruction instead of losing it.

It sits between the testbench/loader and the decode stage.

---
 rtl/fetch_pipe_pkg.sv | 23 ++
 rtl/fetch_pipe_imem_sync.sv | 40 ++++
 rtl/fetch_pipe.sv | 102 ++++++++++
 tb/tb_fetch_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pipe_pkg.sv
// ============================================================================
// Module   : fetch_pipe_pkg
// Brief    : Shared defaults and helpers for the instruction-fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pipe_pkg;

  // Default geometry and reset PC, also used by decode-stage tests
  localparam int C_DEF_IW       = 32;
  localparam int C_DEF_DEPTH    = 32;
  localparam int C_DEF_RESET_PC = 0;

  // Effective wrap index: a limit past the end of memory means "use the whole memory"
  function automatic logic [31:0] clamp_limit(input logic [31:0] limit,
                                              input logic [31:0] depth);
    return (limit >= depth - 32'd1) ? (depth - 32'd1) : limit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pipe_imem_sync.sv
// ============================================================================
// Module   : imem_sync
// Brief    : DEPTH x IW instruction memory, one synchronous write port and a
//            combinational read with same-cycle write forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_sync
  import fetch_pipe_pkg::*;
#(
  parameter int IW    = C_DEF_IW,
  parameter int DEPTH = C_DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] r_mem [DEPTH];
  logic          w_fwd;

  // Contents are deliberately not reset so the array maps onto plain RAM
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // A write landing on the address being read is visible in the same cycle
  assign w_fwd = we && (waddr == raddr);
  assign rdata = w_fwd ? wdata : r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fetch_pipe.sv
// ============================================================================
// Module   : fetch_pipe
// Brief    : Instruction-fetch stage: PC register with runtime wrap limit,
//            redirect, registered output slot with valid/ready toward decode,
//            and an accepted-handshake counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pipe
  import fetch_pipe_pkg::*;
#(
  parameter int IW       = C_DEF_IW,
  parameter int DEPTH    = C_DEF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int RESET_PC = C_DEF_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [AW-1:0] wrap_limit,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [IW-1:0] imem_wdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [31:0]   fetch_count
);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_out_pc;
  logic [IW-1:0] r_out_instr;
  logic          r_out_valid;
  logic [31:0]   r_fetch_count;

  logic [IW-1:0] w_rd_data;
  logic [AW-1:0] w_eff_limit;
  logic [AW-1:0] w_pc_next;
  logic          w_adv;
  logic          w_hs;

  imem_sync #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (r_pc),
    .rdata (w_rd_data)
  );

  // A new fetch happens only when the output slot is free or being drained
  assign w_hs        = r_out_valid & out_ready;
  assign w_adv       = run & ~redirect_valid & (~r_out_valid | out_ready);
  assign w_eff_limit = AW'(clamp_limit(32'(wrap_limit), 32'(DEPTH)));
  // >= rather than == so a redirect past the limit still wraps on its next fetch
  assign w_pc_next   = (r_pc >= w_eff_limit) ? '0 : r_pc + AW'(1);

  // PC and output slot; redirect wins over everything and drops the held fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= AW'(RESET_PC);
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
    end else if (redirect_valid) begin
      r_pc        <= redirect_pc;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_out_instr <= w_rd_data;
      r_out_pc    <= r_pc;
      r_out_valid <= 1'b1;
      r_pc        <= w_pc_next;
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  // Every accepted handshake counts, including one coinciding with a redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_hs) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pipe.sv
// ============================================================================
// Module   : tb_fetch_pipe
// Brief    : Self-checking bench for fetch_pipe against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pipe;

  localparam int IW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [AW-1:0] wrap_limit;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [IW-1:0] imem_wdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_ready;
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [31:0]   fetch_count;

  fetch_pipe #(.IW(IW), .DEPTH(DEPTH), .AW(AW), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .wrap_limit     (wrap_limit),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state: memory image, next-fetch index, output slot, count
  logic [IW-1:0] m_mem [DEPTH];
  int            m_pc;
  bit            m_valid;
  logic [IW-1:0] m_instr;
  int            m_opc;
  int unsigned   m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 0;
    m_valid = 1'b0;
    m_instr = '0;
    m_opc   = 0;
    m_cnt   = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".instr"}, 64'(out_instr), 64'(m_instr));
    chk({tag, ".pc"},    64'(out_pc),    64'(m_opc));
    chk({tag, ".count"}, 64'(fetch_count), 64'(m_cnt));
  endtask

  // One clock: predict from current inputs, clock, then compare everything
  task automatic tick(input string tag);
    int            lim;
    bit            adv;
    bit            hs;
    int            npc;
    bit            nv;
    logic [IW-1:0] ni;
    int            nop;
    npc = m_pc; nv = m_valid; ni = m_instr; nop = m_opc;
    lim = (int'(wrap_limit) >= DEPTH - 1) ? DEPTH - 1 : int'(wrap_limit);
    hs  = m_valid && out_ready;
    adv = run && !redirect_valid && (!m_valid || out_ready);
    if (redirect_valid) begin
      nv  = 1'b0;
      npc = int'(redirect_pc);
    end else if (adv) begin
      ni  = (imem_we && int'(imem_waddr) == m_pc) ? imem_wdata : m_mem[m_pc];
      nop = m_pc;
      nv  = 1'b1;
      npc = (m_pc >= lim) ? 0 : m_pc + 1;
    end else if (hs) begin
      nv = 1'b0;
    end
    @(posedge clk);
    #1;
    if (hs) m_cnt++;
    if (imem_we) m_mem[imem_waddr] = imem_wdata;
    m_pc = npc; m_valid = nv; m_instr = ni; m_opc = nop;
    chk_all(tag);
  endtask

  initial begin
    int            k;
    logic [AW-1:0] held_pc;
    logic [IW-1:0] held_instr;

    rst_n = 1'b0; run = 1'b0; wrap_limit = 5'd9; imem_we = 1'b0;
    imem_waddr = '0; imem_wdata = '0; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b0;
    model_reset();
    #12;
    chk_all("reset");
    rst_n = 1'b1;

    // Load the whole memory; the first ten words are easy to recognise
    for (int i = 0; i < DEPTH; i++) begin
      imem_we    = 1'b1;
      imem_waddr = AW'(i);
      imem_wdata = (i < 10) ? (32'hA000_0000 + 32'(i) * 32'h111) : $urandom;
      tick("load");
    end
    imem_we = 1'b0;

    // Sequential fetch with wrap at 9
    run = 1'b1; out_ready = 1'b1; wrap_limit = 5'd9;
    for (int i = 0; i < 12; i++) begin
      tick("seq");
      chk("seq_order", 64'(out_pc), 64'(i % 10));
    end
    tick("seq_last");
    chk("seq_count12", 64'(fetch_count), 64'd12);

    // Backpressure while index 4 is presented
    k = 0;
    while (!(m_valid && m_opc == 4) && k < 40) begin tick("to4"); k++; end
    chk("reach_pc4", 64'(out_pc), 64'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall_pc", 64'(out_pc), 64'd4);
      chk("stall_instr", 64'(out_instr), 64'h0000_0000_A000_0444);
    end
    out_ready = 1'b1;
    tick("unstall");
    chk("after_stall_pc", 64'(out_pc), 64'd5);

    // Redirect to 7 while index 2 is stalled
    k = 0;
    while (!(m_valid && m_opc == 2) && k < 40) begin tick("to2"); k++; end
    chk("reach_pc2", 64'(out_pc), 64'd2);
    out_ready = 1'b0;
    tick("stall2");
    redirect_valid = 1'b1; redirect_pc = 5'd7;
    tick("redir");
    chk("redir_valid0", 64'(out_valid), 64'd0);
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick("redir_tgt");
    chk("redir_pc7", 64'(out_pc), 64'd7);
    chk("redir_valid1", 64'(out_valid), 64'd1);

    // Write forwarding when index 3 is fetched
    k = 0;
    while (m_pc != 3 && k < 40) begin tick("to3"); k++; end
    imem_we = 1'b1; imem_waddr = 5'd3; imem_wdata = 32'hDEAD_BEEF;
    tick("fwd");
    imem_we = 1'b0;
    chk("fwd_instr", 64'(out_instr), 64'h0000_0000_DEAD_BEEF);
    chk("fwd_pc", 64'(out_pc), 64'd3);

    // A write elsewhere must not disturb a held instruction
    out_ready = 1'b0;
    held_instr = out_instr;
    imem_we = 1'b1; imem_waddr = 5'd0; imem_wdata = $urandom;
    tick("wr_other");
    imem_we = 1'b0;
    chk("held_instr", 64'(out_instr), 64'(held_instr));

    // Run drops while the slot drains: valid falls, pc holds
    out_ready = 1'b1; run = 1'b0;
    held_pc = out_pc;
    tick("run0");
    chk("run0_valid", 64'(out_valid), 64'd0);
    tick("run0b");
    run = 1'b1;
    tick("run1");
    chk("run1_pc", 64'(out_pc), 64'(held_pc + 5'd1));

    // Redirect past the wrap limit fetches the target then wraps to 0
    wrap_limit = 5'd5;
    redirect_valid = 1'b1; redirect_pc = 5'd8;
    tick("redir_hi");
    redirect_valid = 1'b0;
    tick("hi_tgt");
    chk("hi_tgt_pc", 64'(out_pc), 64'd8);
    tick("hi_wrap");
    chk("hi_wrap_pc", 64'(out_pc), 64'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      run            = ($urandom % 8) != 0;
      out_ready      = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = AW'($urandom);
      imem_we        = ($urandom % 3) == 0;
      imem_waddr     = AW'($urandom);
      imem_wdata     = $urandom;
      if (i % 32 == 0) wrap_limit = AW'($urandom);
      tick("rand");
    end

    // Asynchronous reset mid-stream
    run = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; imem_we = 1'b0;
    wrap_limit = 5'd31;
    tick("pre_rst");
    tick("pre_rst2");
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    #2 rst_n = 1'b1;
    tick("post_rst");
    chk("post_rst_pc", 64'(out_pc), 64'd0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    tick("post_rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
